// File: rtl/apb_pkg.sv
// Shared APB types and constants for the arbitrated APB master and its
// memory-side neighbours.
package apb_pkg;

    localparam int APB_ADDR_W     = 32;
    localparam int APB_DATA_W     = 32;
    localparam int APB_STRB_W     = APB_DATA_W / 8;
    localparam int APB_WDOG_WIDTH = 8;

    typedef logic [APB_ADDR_W-1:0] addr_t;
    typedef logic [APB_DATA_W-1:0] data_t;
    typedef logic [APB_STRB_W-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
        strb_t strb;
    } apb_cmd_t;

endpackage

// File: rtl/apb_arb_master_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        // Walk from the farthest candidate down so the nearest one wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Round-robin arbiter + APB master sequencer with an ACCESS-phase watchdog;
// completions are reported one cycle later to the requester that owned them.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                                PCLK,
    input  logic                                PRESETn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ-1:0][APB_ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][APB_DATA_W-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0][APB_STRB_W-1:0]  req_strb,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [APB_DATA_W-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic                                rsp_timeout,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [APB_ADDR_W-1:0]               PADDR,
    output logic [APB_DATA_W-1:0]               PWDATA,
    output logic [APB_STRB_W-1:0]               PSTRB,
    input  logic [APB_DATA_W-1:0]               PRDATA,
    input  logic                                PREADY,
    input  logic                                PSLVERR
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [APB_WDOG_WIDTH-1:0] WDOG_LAST = APB_WDOG_WIDTH'(TIMEOUT - 1);

    arb_state_e                state_q, state_d;
    logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]           owner_q, owner_d;
    logic [APB_WDOG_WIDTH-1:0] wdog_q, wdog_d;
    apb_cmd_t                  cmd_q, cmd_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    data_t                     rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic               in_access, wdog_exp, done, arb_pt, take;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // PREADY wins over a coincident watchdog expiry.
    always_comb begin
        in_access = (state_q == ACCESS);
        wdog_exp  = in_access && !PREADY && (wdog_q == WDOG_LAST);
        done      = in_access && (PREADY || wdog_exp);
        arb_pt    = (state_q == IDLE) || done;
        take      = arb_pt && gnt_any;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            wdog_q        <= '0;
            cmd_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            wdog_q        <= wdog_d;
            cmd_q         <= cmd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = take ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        if (take) begin
            rr_ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            owner_d     = gnt_id;
            cmd_d.write = req_write[gnt_id];
            cmd_d.addr  = req_addr[gnt_id];
            cmd_d.wdata = req_wdata[gnt_id];
            cmd_d.strb  = req_write[gnt_id] ? req_strb[gnt_id] : '0;
        end

        wdog_d = wdog_q;
        if (state_q == SETUP)                    wdog_d = '0;
        else if (in_access && !PREADY && !wdog_exp) wdog_d = wdog_q + 1'b1;

        rsp_valid_d = '0;
        if (done) rsp_valid_d[owner_q] = 1'b1;
        rsp_rdata_d   = (done && PREADY && !cmd_q.write) ? PRDATA : '0;
        rsp_err_d     = done && (PREADY ? PSLVERR : 1'b1);
        rsp_timeout_d = done && !PREADY;
    end

    // req_ready is held low while reset is asserted even though it is combinational.
    always_comb begin
        PSEL      = (state_q != IDLE);
        PENABLE   = in_access;
        req_ready = (PRESETn && arb_pt) ? gnt : '0;
    end

    assign PWRITE      = cmd_q.write;
    assign PADDR       = cmd_q.addr;
    assign PWDATA      = cmd_q.wdata;
    assign PSTRB       = cmd_q.strb;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: APB memory stub (2-cycle reads, 4-cycle writes,
// write-protected 0x0-0xF, hung address 0x80) plus an in-order response scoreboard.
module tb_apb_arb_master;

    localparam int NR = 4;
    localparam logic [31:0] HANG_ADDR = 32'h80;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [NR-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [NR-1:0][31:0] req_addr, req_wdata;
    logic [NR-1:0][3:0]  req_strb;
    logic [31:0]     rsp_rdata;
    logic            rsp_err, rsp_timeout;
    logic            PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0]     PADDR, PWDATA, PRDATA;
    logic [3:0]      PSTRB;

    apb_arb_master #(.NUM_REQ(NR), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave stub
    logic [31:0] slave_mem [64];
    int          acc_cnt = 0;
    logic        pl_en;
    logic [31:0] pl_addr, pl_data;

    assign PREADY  = PSEL && PENABLE && (PADDR != HANG_ADDR) && (acc_cnt == (PWRITE ? 3 : 1));
    assign PSLVERR = PREADY && PWRITE && (PADDR < 32'h10);
    assign PRDATA  = slave_mem[PADDR[7:2]];

    always @(posedge PCLK) begin
        if (pl_en) slave_mem[pl_addr[7:2]] <= pl_data;
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PREADY && PWRITE && !PSLVERR)
            for (int b = 0; b < 4; b++)
                if (PSTRB[b]) slave_mem[PADDR[7:2]][8*b +: 8] <= PWDATA[8*b +: 8];
    end

    // Scoreboard / reference state
    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [64];
    logic        c_wr    [NR];
    logic [31:0] c_addr  [NR];
    logic [31:0] c_wdata [NR];
    logic [3:0]  c_strb  [NR];
    logic        psel_tr [256];
    logic        pen_tr  [256];
    int          acc_cyc [NR];
    int          gnt_q[$];
    int          rsp_cyc_q[$];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          errors = 0;

    task automatic set_cmd(input int id, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        c_wr[id] = wr; c_addr[id] = a; c_wdata[id] = d; c_strb[id] = s;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a[7:2]] = d;
        @(posedge PCLK); #2;
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0; req_valid = '0;
        repeat (2) begin @(posedge PCLK); #2; end
        PRESETn = 1'b1;
    endtask

    function automatic exp_t model(input int id);
        exp_t        e;
        logic [31:0] w;
        e.id = id; e.rdata = '0; e.err = 1'b0; e.to = 1'b0;
        w = c_addr[id];
        if (w == HANG_ADDR) begin
            e.err = 1'b1; e.to = 1'b1;
        end else if (c_wr[id]) begin
            if (w < 32'h10) e.err = 1'b1;
            else
                for (int b = 0; b < 4; b++)
                    if (c_strb[id][b]) ref_mem[w[7:2]][8*b +: 8] = c_wdata[id][8*b +: 8];
        end else begin
            e.rdata = ref_mem[w[7:2]];
        end
        return e;
    endfunction

    // Drives the masked requesters until accepted and collects nrsp responses.
    task automatic run(input logic [NR-1:0] mask, input int nrsp, input int budget);
        logic [NR-1:0] pend;
        int            got, cyc;
        exp_t          e;
        pend = mask; got = 0; cyc = 0;
        for (int i = 0; i < NR; i++) if (mask[i]) begin
            req_write[i] = c_wr[i]; req_addr[i] = c_addr[i];
            req_wdata[i] = c_wdata[i]; req_strb[i] = c_strb[i];
        end
        req_valid = mask;
        while ((pend != '0 || got < nrsp) && cyc < budget) begin
            @(negedge PCLK);
            psel_tr[cyc] = PSEL; pen_tr[cyc] = PENABLE;
            if (rsp_valid != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got valid=%b", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== 4'(1 << e.id) || rsp_err !== e.err || rsp_timeout !== e.to ||
                        (!e.to && rsp_rdata !== e.rdata)) begin
                        errors++;
                        $display("FAIL rsp got v=%b d=%h err=%b to=%b exp v=%b d=%h err=%b to=%b",
                                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                                 4'(1 << e.id), e.rdata, e.err, e.to);
                    end
                end
                got++; rsp_cyc_q.push_back(cyc); last_rdata = rsp_rdata;
            end
            for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) begin
                sb.push_back(model(i));
                acc_cyc[i] = cyc; gnt_q.push_back(i); pend[i] = 1'b0;
            end
            @(posedge PCLK); #2;
            req_valid = req_valid & pend;
            cyc++;
        end
        if (pend != '0 || got < nrsp) begin
            checks++; errors++;
            $display("FAIL run_timeout pending=%b rsps=%0d need=%0d", pend, got, nrsp);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; req_valid = 4'b0001;
        req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b0 || PADDR !== 0 || PWDATA !== 0 || PSTRB !== 0) begin
            errors++;
            $display("FAIL reset_apb got psel=%b pen=%b pwr=%b paddr=%h exp 0", PSEL, PENABLE, PWRITE, PADDR);
        end
        checks++;
        if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        checks++;
        if (rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0 || rsp_timeout !== 0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b d=%h e=%b t=%b exp 0", rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
        req_valid = '0;
        @(posedge PCLK); #2;
        PRESETn = 1'b1;
    endtask

    task automatic test_single_read();
        int a;
        preload(32'h20, 32'hDEADBEEF);
        rsp_cyc_q.delete();
        set_cmd(2, 1'b0, 32'h20, 32'h0, 4'hF);
        run(4'b0100, 1, 20);
        a = acc_cyc[2];
        checks++;
        if (psel_tr[a+1] !== 1'b1 || pen_tr[a+1] !== 1'b0) begin
            errors++; $display("FAIL rd_setup got psel=%b pen=%b exp 1 0", psel_tr[a+1], pen_tr[a+1]);
        end
        checks++;
        if ({psel_tr[a+2], pen_tr[a+2], psel_tr[a+3], pen_tr[a+3]} !== 4'b1111) begin
            errors++; $display("FAIL rd_access got %b exp 1111", {psel_tr[a+2], pen_tr[a+2], psel_tr[a+3], pen_tr[a+3]});
        end
        checks++;
        if (psel_tr[a+4] !== 1'b0) begin errors++; $display("FAIL rd_idle got psel=%b exp 0", psel_tr[a+4]); end
        checks++;
        if (rsp_cyc_q.size() != 1 || rsp_cyc_q[0] != a + 4) begin
            errors++; $display("FAIL rd_latency got %0d exp %0d", (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - a : -1, 4);
        end
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", last_rdata); end
    endtask

    task automatic test_fairness();
        do_reset();
        gnt_q.delete();
        for (int i = 0; i < NR; i++) set_cmd(i, 1'b1, 32'h100 + 32'(i) * 4, 32'hA000 + 32'(i), 4'hF);
        run(4'b1111, 4, 80);
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (gnt_q.size() <= i || gnt_q[i] != i) begin
                errors++; $display("FAIL fair_order idx=%0d got %0d exp %0d", i, (gnt_q.size() > i) ? gnt_q[i] : -1, i);
            end
        end
        for (int i = 0; i < NR - 1; i++) begin
            checks++;
            if (acc_cyc[i+1] - acc_cyc[i] != 5) begin
                errors++; $display("FAIL fair_b2b idx=%0d got gap %0d exp 5", i, acc_cyc[i+1] - acc_cyc[i]);
            end
        end
        gnt_q.delete();
        set_cmd(0, 1'b1, 32'h120, 32'hB0, 4'hF);
        set_cmd(3, 1'b1, 32'h12C, 32'hB3, 4'hF);
        run(4'b1001, 2, 40);
        checks++;
        if (gnt_q.size() != 2 || gnt_q[0] != 0 || gnt_q[1] != 3) begin
            errors++; $display("FAIL fair_rereq got %0d,%0d exp 0,3",
                               (gnt_q.size() > 0) ? gnt_q[0] : -1, (gnt_q.size() > 1) ? gnt_q[1] : -1);
        end
        checks++;
        if (acc_cyc[3] - acc_cyc[0] != 5) begin
            errors++; $display("FAIL fair_rereq_b2b got gap %0d exp 5", acc_cyc[3] - acc_cyc[0]);
        end
    endtask

    task automatic test_write_readback();
        preload(32'h40, 32'h0);
        set_cmd(1, 1'b1, 32'h40, 32'h11223344, 4'b0101);
        run(4'b0010, 1, 30);
        set_cmd(1, 1'b0, 32'h40, 32'h0, 4'hF);
        run(4'b0010, 1, 30);
        checks++;
        if (last_rdata !== 32'h00220044) begin errors++; $display("FAIL wr_readback got %h exp 00220044", last_rdata); end
    endtask

    task automatic test_read_only();
        preload(32'h04, 32'hA5A5A5A5);
        set_cmd(2, 1'b1, 32'h05, 32'h12345678, 4'hF);
        run(4'b0100, 1, 30);
        set_cmd(2, 1'b0, 32'h04, 32'h0, 4'hF);
        run(4'b0100, 1, 30);
        checks++;
        if (last_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL ro_unchanged got %h exp a5a5a5a5", last_rdata); end
    endtask

    task automatic test_watchdog();
        int  a;
        logic all_sel, all_en;
        do_reset();
        gnt_q.delete(); rsp_cyc_q.delete();
        set_cmd(0, 1'b0, HANG_ADDR, 32'h0, 4'hF);
        set_cmd(1, 1'b0, 32'h20, 32'h0, 4'hF);
        run(4'b0011, 2, 60);
        a = acc_cyc[0];
        all_sel = 1'b1; all_en = 1'b1;
        for (int k = 1; k <= 17; k++) all_sel &= psel_tr[a+k];
        for (int k = 2; k <= 17; k++) all_en &= pen_tr[a+k];
        checks++;
        if (all_sel !== 1'b1 || pen_tr[a+1] !== 1'b0 || all_en !== 1'b1) begin
            errors++; $display("FAIL wd_phases got sel=%b setup_en=%b acc_en=%b exp 1 0 1", all_sel, pen_tr[a+1], all_en);
        end
        checks++;
        if (rsp_cyc_q.size() < 1 || rsp_cyc_q[0] != a + 18) begin
            errors++; $display("FAIL wd_rsp_cycle got %0d exp %0d", (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - a : -1, 18);
        end
        checks++;
        if (acc_cyc[1] != a + 17 || psel_tr[a+18] !== 1'b1 || pen_tr[a+18] !== 1'b0) begin
            errors++; $display("FAIL wd_next_setup got accept %0d psel=%b pen=%b exp 17 1 0",
                               acc_cyc[1] - a, psel_tr[a+18], pen_tr[a+18]);
        end
    endtask

    task automatic test_reset_mid();
        gnt_q.delete();
        set_cmd(2, 1'b1, HANG_ADDR, 32'hCAFE, 4'hF);
        run(4'b0100, 0, 10);
        @(negedge PCLK);
        @(posedge PCLK); #2;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++; $display("FAIL mid_in_access got psel=%b pen=%b exp 1 1", PSEL, PENABLE);
        end
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b0 || PADDR !== 0 || PWDATA !== 0 || PSTRB !== 0 ||
            req_ready !== 0 || rsp_valid !== 0 || rsp_err !== 0 || rsp_timeout !== 0 || rsp_rdata !== 0) begin
            errors++; $display("FAIL mid_async got psel=%b pen=%b paddr=%h rspv=%b exp all 0", PSEL, PENABLE, PADDR, rsp_valid);
        end
        sb.delete();
        repeat (2) begin
            @(negedge PCLK);
            checks++;
            if (rsp_valid !== 0) begin errors++; $display("FAIL mid_no_rsp got %b exp 0000", rsp_valid); end
        end
        @(posedge PCLK); #2;
        PRESETn = 1'b1;
        gnt_q.delete();
        set_cmd(0, 1'b0, 32'h20, 32'h0, 4'hF);
        set_cmd(3, 1'b0, 32'h40, 32'h0, 4'hF);
        run(4'b1001, 2, 40);
        checks++;
        if (gnt_q.size() < 1 || gnt_q[0] != 0) begin
            errors++; $display("FAIL mid_first_grant got %0d exp 0", (gnt_q.size() > 0) ? gnt_q[0] : -1);
        end
    endtask

    initial begin
        pl_en = 1'b0; pl_addr = '0; pl_data = '0; last_rdata = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_write_readback();
        test_read_only();
        test_watchdog();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d left exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
